// File: rtl/key_debounce.sv
// key_debounce: push-button front end for the DE10-Lite counter designs.
// Two-flop synchroniser, consecutive-sample debouncer, registered press and
// release pulses, and a step pulse for a counter enable.
// Optional auto-repeat is compiled in when KEY_AUTOREPEAT_EN is defined.
// Without it, step_pulse follows press_pulse and held is tied low.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse,
  output logic held
);

  localparam int unsigned       DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic              RAW_RELEASED = ACTIVE_LOW;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_key_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press_pulse;
  logic            r_release_pulse;

  logic w_sync_n;
  logic w_differ;
  logic w_accept;
  logic w_press_acc;
  logic w_release_acc;

  // Two-stage synchroniser; both stages come out of reset at the released level.
  // NOTE: sequential state always uses non-blocking assignments, so every
  // flop samples the pre-edge value of its neighbours regardless of ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= RAW_RELEASED;
      r_sync2 <= RAW_RELEASED;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalise polarity so that 1 always means pressed.
  assign w_sync_n      = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_differ      = (w_sync_n != r_key_level);
  assign w_accept      = w_differ && (r_db_cnt == DB_LAST);
  assign w_press_acc   = w_accept && !r_key_level;
  assign w_release_acc = w_accept &&  r_key_level;

  // Debouncer: count consecutive differing samples, flip the level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_level <= 1'b0;
      r_db_cnt    <= '0;
    end else if (!w_differ) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_key_level <= ~r_key_level;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // Edge pulses land on the same edge as the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_press_pulse   <= w_press_acc;
      r_release_pulse <= w_release_acc;
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_t;

  rpt_state_t      r_state;
  logic [RP_W-1:0] r_rpt_cnt;
  logic            r_step;
  logic            r_held;

  // Repeat FSM; a release always wins over a coinciding terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rpt_cnt <= '0;
      r_step    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press_acc) begin
            r_state   <= ST_DELAY;
            r_rpt_cnt <= '0;
            r_step    <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (w_release_acc) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_held    <= 1'b0;
          end else if (r_rpt_cnt == RD_LAST) begin
            r_state   <= ST_REPEAT;
            r_rpt_cnt <= '0;
            r_step    <= 1'b1;
            r_held    <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + RP_W'(1);
          end
        end
        ST_REPEAT: begin
          if (w_release_acc) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_held    <= 1'b0;
          end else if (r_rpt_cnt == RP_LAST) begin
            r_rpt_cnt <= '0;
            r_step    <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + RP_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rpt_cnt <= '0;
          r_held    <= 1'b0;
        end
      endcase
    end
  end

  assign step_pulse = r_step;
  assign held       = r_held;
`else
  assign step_pulse = r_press_pulse;
  assign held       = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a sliding-window reference model.
module tb_key_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam bit AL = 1'b1;

  logic clk = 1'b0;
  logic reset;
  logic key_in;
  logic key_level, press_pulse, release_pulse, step_pulse, held;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse),
    .held         (held)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: history of pressed samples (one per edge), newest last.
  bit hist[$];
  bit m_level, m_press, m_release, m_step, m_held;
  int m_press_cyc;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("key_level",     key_level,     m_level);
    chk("press_pulse",   press_pulse,   m_press);
    chk("release_pulse", release_pulse, m_release);
    chk("step_pulse",    step_pulse,    m_step);
    chk("held",          held,          m_held);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    m_level     = 1'b0;
    m_press     = 1'b0;
    m_release   = 1'b0;
    m_step      = 1'b0;
    m_held      = 1'b0;
    m_press_cyc = -1;
  endtask

  // The level flips once the D samples that have crossed the synchroniser
  // (the oldest D of the last D+2 edges) all disagree with it.
  task automatic tick();
    bit pressed;
    bit all_diff;
    int off;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      pressed = AL ? ~key_in : key_in;
      hist.push_back(pressed);
      void'(hist.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (hist[i] == m_level) all_diff = 1'b0;
      m_press   = all_diff && !m_level;
      m_release = all_diff &&  m_level;
      if (all_diff) m_level = ~m_level;
      if (m_press) m_press_cyc = cyc;
      if (m_level) begin
        off = cyc - m_press_cyc;
`ifdef KEY_AUTOREPEAT_EN
        m_step = (off == 0) || (off >= RD && ((off - RD) % RP) == 0);
        m_held = (off >= RD);
`else
        m_step = (off == 0);
        m_held = 1'b0;
`endif
      end else begin
        m_step = 1'b0;
        m_held = 1'b0;
      end
    end
    #1 check_all();
  endtask

  task automatic set_key(input bit p);
    key_in = AL ? ~p : p;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    set_key(1'b0);
    model_reset();
    #2 check_all();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Clean press, then hold 30 cycles past acceptance for auto-repeat
    set_key(1'b1);
    repeat (36) tick();
    set_key(1'b0);
    repeat (10) tick();

    // Releases landing around repeat terminal counts
    for (int h = 14; h <= 17; h++) begin
      set_key(1'b1);
      repeat (6 + h) tick();
      set_key(1'b0);
      repeat (8) tick();
    end

    // Bounce rejection: 3 pressed / 1 released, five times
    repeat (5) begin
      set_key(1'b1);
      repeat (3) tick();
      set_key(1'b0);
      tick();
    end
    repeat (8) tick();

    // Random bouncing runs of 1..8 cycles
    repeat (60) begin
      set_key(1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 8)) tick();
    end
    set_key(1'b0);
    repeat (10) tick();

    // Reset while held in the repeat phase, key kept pressed
    set_key(1'b1);
    repeat (20) tick();
    reset = 1'b1;
    model_reset();
    #1 check_all();
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    set_key(1'b0);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
